// File: rtl/nec_prefetch.sv
// nec_prefetch: NEC V20/V30-style instruction prefetch queue with a word-wide bus fetcher
// Ports: clk, reset (sync, active-high), ce (clock enable)
//   set_pc/new_pc  flush the queue and restart fetching at new_pc within segment ps
//   ps, decode_pc  segment base and oldest byte still needed by the decoder
//   fetch_req/fetch_addr/fetch_ack/fetch_data  bus read handshake, 20-bit physical address
//   ipq/ipq_len    8 address-indexed byte slots and the count of valid bytes from decode_pc
// NEC_IPQ_LIMIT6_EN limits the queue to 6 bytes (V30 depth) instead of 8.
module nec_prefetch #(
`ifdef NEC_IPQ_LIMIT6_EN
  parameter int IPQ_MAX = 6
`else
  parameter int IPQ_MAX = 8
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic            set_pc,
  input  logic [15:0]     new_pc,
  input  logic [15:0]     ps,
  input  logic [15:0]     decode_pc,
  output logic            fetch_req,
  output logic [19:0]     fetch_addr,
  input  logic            fetch_ack,
  input  logic [15:0]     fetch_data,
  output logic [7:0][7:0] ipq,
  output logic [3:0]      ipq_len
);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d, len_c;
  logic [3:0] ipq_len_q, ipq_len_d;
  logic [19:0] fetch_addr_q, fetch_addr_d;
  logic [7:0][7:0] ipq_q, ipq_d;
  logic [2:0] slot, slot_n;
  logic can_fetch;
  // Free space is judged from the live fetch_pc so the IDLE cycle right after an ack
  // never sees the stale registered length and over-fetches.
  assign len_c = fetch_pc_q - decode_pc;
  assign can_fetch = fetch_pc_q[0] ? (len_c <= 16'(IPQ_MAX - 1)) : (len_c <= 16'(IPQ_MAX - 2));
  assign slot = fetch_pc_q[2:0];
  assign slot_n = slot + 3'd1;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    ipq_len_d = fetch_pc_q[3:0] - decode_pc[3:0];
    fetch_addr_d = fetch_addr_q;
    ipq_d = ipq_q;
    case (state_q)
      IDLE: if (!set_pc && can_fetch) begin
        state_d = REQ;
        fetch_addr_d = {ps, 4'h0} + {4'h0, fetch_pc_q};
      end
      REQ: if (fetch_ack) begin
        state_d = IDLE;
        if (!set_pc) begin
          if (fetch_pc_q[0]) begin
            ipq_d[slot] = fetch_data[15:8];
            fetch_pc_d = fetch_pc_q + 16'd1;
          end else begin
            ipq_d[slot] = fetch_data[7:0];
            ipq_d[slot_n] = fetch_data[15:8];
            fetch_pc_d = fetch_pc_q + 16'd2;
          end
        end
      end else if (set_pc) state_d = DISCARD;
      DISCARD: state_d = fetch_ack ? IDLE : DISCARD;
      default: state_d = IDLE;
    endcase
    if (set_pc) begin
      fetch_pc_d = new_pc;
      ipq_len_d = 4'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= 16'd0;
      ipq_len_q <= 4'd0;
      fetch_addr_q <= 20'd0;
      ipq_q <= '0;
    end else if (ce) begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ipq_len_q <= ipq_len_d;
      fetch_addr_q <= fetch_addr_d;
      ipq_q <= ipq_d;
    end
  end
  assign fetch_req = state_q != IDLE;
  assign fetch_addr = fetch_addr_q;
  assign ipq = ipq_q;
  assign ipq_len = ipq_len_q;
endmodule

// File: tb/tb_nec_prefetch.sv
// tb_nec_prefetch: table-driven and scoreboard checks for nec_prefetch
module tb_nec_prefetch;
`ifdef NEC_IPQ_LIMIT6_EN
  localparam int MAXQ = 6;
`else
  localparam int MAXQ = 8;
`endif
  logic clk = 1'b0, reset, ce, set_pc, fetch_req, fetch_ack;
  logic [15:0] new_pc, ps, decode_pc, fetch_data;
  logic [19:0] fetch_addr;
  logic [7:0][7:0] ipq;
  logic [3:0] ipq_len;
  logic [19:0] exp_q[$];
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] pc, ps, data;
    logic [19:0] addr, nxt;
    logic [3:0] len;
    logic [7:0] b0, b1;
  } vec_t;
  vec_t tbl[7];
  nec_prefetch dut (
    .clk(clk), .reset(reset), .ce(ce), .set_pc(set_pc), .new_pc(new_pc), .ps(ps),
    .decode_pc(decode_pc), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .ipq(ipq), .ipq_len(ipq_len)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic wait_req(input string n);
    int k = 0;
    while (!fetch_req && k < 20) begin
      tick();
      k++;
    end
    chk({n, " req"}, 32'(fetch_req), 32'd1);
    chk({n, " addr"}, 32'(fetch_addr), 32'(exp_q.pop_front()));
  endtask
  task automatic bus_cycle(input string n, input logic [15:0] d);
    wait_req(n);
    fetch_ack = 1'b1;
    fetch_data = d;
    tick();
    fetch_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{16'h0100, 16'hF000, 16'h1122, 20'hF0100, 20'hF0102, 4'd2, 8'h22, 8'h11};
    tbl[1] = '{16'h0013, 16'hF000, 16'hAABB, 20'hF0013, 20'hF0014, 4'd1, 8'hAA, 8'h00};
    tbl[2] = '{16'h0007, 16'h1234, 16'h5566, 20'h12347, 20'h12348, 4'd1, 8'h55, 8'h00};
    tbl[3] = '{16'h0006, 16'hFFFF, 16'h7788, 20'hFFFF6, 20'hFFFF8, 4'd2, 8'h88, 8'h77};
    tbl[4] = '{16'hFFFE, 16'hFFFF, 16'h1234, 20'h0FFEE, 20'hFFFF0, 4'd2, 8'h34, 8'h12};
    tbl[5] = '{16'h000F, 16'h0000, 16'h9A9B, 20'h0000F, 20'h00010, 4'd1, 8'h9A, 8'h00};
    tbl[6] = '{16'hFFFF, 16'h0001, 16'hC3D4, 20'h1000F, 20'h00010, 4'd1, 8'hC3, 8'h00};
    reset = 1'b1; ce = 1'b0; set_pc = 1'b0; new_pc = 16'h0; ps = 16'h0;
    decode_pc = 16'h0; fetch_ack = 1'b0; fetch_data = 16'h0;
    tick();
    tick();
    chk("rst req", 32'(fetch_req), 32'd0);
    chk("rst addr", 32'(fetch_addr), 32'd0);
    chk("rst len", 32'(ipq_len), 32'd0);
    chk("rst ipq", 32'(ipq[3:0]), 32'd0);
    chk("rst ipq hi", 32'(ipq[7:4]), 32'd0);
    reset = 1'b0; ce = 1'b1; ps = 16'hF000; new_pc = 16'h0100; decode_pc = 16'h0100; set_pc = 1'b1;
    tick();
    set_pc = 1'b0;
    chk("setpc len", 32'(ipq_len), 32'd0);
    for (int i = 0; i < MAXQ / 2; i++) exp_q.push_back(20'hF0100 + 20'(2 * i));
    for (int i = 0; i < MAXQ / 2; i++) bus_cycle("fill", {8'(8'hA1 + 2 * i), 8'(8'hA0 + 2 * i)});
    repeat (4) tick();
    chk("full len", 32'(ipq_len), 32'(MAXQ));
    chk("full idle", 32'(fetch_req), 32'd0);
    for (int i = 0; i < MAXQ; i++) chk("fill byte", 32'(ipq[i]), 32'(8'hA0 + i));
    decode_pc = 16'h0102;
    exp_q.push_back(20'hF0100 + 20'(MAXQ));
    bus_cycle("refill", 16'hB1B0);
    repeat (4) tick();
    chk("refill idle", 32'(fetch_req), 32'd0);
    chk("refill len", 32'(ipq_len), 32'(MAXQ));
    chk("refill byte", 32'(ipq[3'(MAXQ)]), 32'h0B0);
    for (int i = 0; i < 7; i++) begin
      logic [2:0] s0, s1;
      s0 = tbl[i].pc[2:0];
      s1 = s0 + 3'd1;
      fetch_ack = fetch_req;
      fetch_data = 16'hDEAD;
      set_pc = 1'b1; new_pc = tbl[i].pc; ps = tbl[i].ps; decode_pc = tbl[i].pc;
      tick();
      set_pc = 1'b0; fetch_ack = 1'b0;
      exp_q.push_back(tbl[i].addr);
      bus_cycle("vec", tbl[i].data);
      tick();
      chk("vec len", 32'(ipq_len), 32'(tbl[i].len));
      chk("vec b0", 32'(ipq[s0]), 32'(tbl[i].b0));
      if (tbl[i].len == 4'd2) chk("vec b1", 32'(ipq[s1]), 32'(tbl[i].b1));
      exp_q.push_back(tbl[i].nxt);
      wait_req("vec next");
    end
    fetch_ack = 1'b1; fetch_data = 16'hDEAD;
    set_pc = 1'b1; new_pc = 16'hFFFE; ps = 16'h0000; decode_pc = 16'hFFFC;
    tick();
    set_pc = 1'b0; fetch_ack = 1'b0;
    exp_q.push_back(20'h0FFFE);
    bus_cycle("wrap", 16'h1234);
    tick();
    chk("wrap b6", 32'(ipq[6]), 32'h34);
    chk("wrap b7", 32'(ipq[7]), 32'h12);
    chk("wrap len", 32'(ipq_len), 32'd4);
    exp_q.push_back(20'h00000);
    wait_req("wrap next");
    ce = 1'b0; fetch_ack = 1'b1; fetch_data = 16'h5A5A;
    tick();
    fetch_ack = 1'b0; ce = 1'b1;
    chk("ce0 req", 32'(fetch_req), 32'd1);
    chk("ce0 addr", 32'(fetch_addr), 32'd0);
    chk("ce0 b0", 32'(ipq[0]), 32'h22);
    set_pc = 1'b1; new_pc = 16'h0020; decode_pc = 16'h0020;
    tick();
    set_pc = 1'b0;
    repeat (3) tick();
    chk("disc req", 32'(fetch_req), 32'd1);
    chk("disc addr", 32'(fetch_addr), 32'd0);
    chk("disc len", 32'(ipq_len), 32'd0);
    set_pc = 1'b1; new_pc = 16'h0030; decode_pc = 16'h0030;
    tick();
    set_pc = 1'b0;
    chk("disc2 req", 32'(fetch_req), 32'd1);
    fetch_ack = 1'b1; fetch_data = 16'hEEFF;
    tick();
    fetch_ack = 1'b0;
    chk("disc drop b0", 32'(ipq[0]), 32'h22);
    chk("disc drop b1", 32'(ipq[1]), 32'h11);
    exp_q.push_back(20'h00030);
    bus_cycle("post disc", 16'h0102);
    tick();
    chk("post disc b0", 32'(ipq[0]), 32'h02);
    chk("post disc b1", 32'(ipq[1]), 32'h01);
    chk("post disc len", 32'(ipq_len), 32'd2);
    exp_q.push_back(20'h00032);
    wait_req("pre rst");
    ce = 1'b0; reset = 1'b1;
    tick();
    chk("rst req2", 32'(fetch_req), 32'd0);
    chk("rst len2", 32'(ipq_len), 32'd0);
    chk("rst addr2", 32'(fetch_addr), 32'd0);
    reset = 1'b0; ce = 1'b1; decode_pc = 16'h0; fetch_ack = 1'b1; fetch_data = 16'hFFFF;
    tick();
    fetch_ack = 1'b0;
    chk("late ack ipq", 32'(ipq[3:0]), 32'd0);
    exp_q.push_back(20'h00000);
    wait_req("post rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nec_prefetch.md
NEC_PREFETCH -- requirements
Module: nec_prefetch

Interface
REQ-001 The block SHALL have the parameter IPQ_MAX, default 8, which sets the maximum number of valid bytes held in the queue. It is 6 when NEC_IPQ_LIMIT6_EN is defined.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ce  input  1  clock enable; state SHALL advance only when ce=1, except for reset.
REQ-005 set_pc  input  1  flush the queue and restart fetching at new_pc.
REQ-006 new_pc  input  16  restart offset within the PS segment.
REQ-007 ps  input  16  program segment base.
REQ-008 decode_pc  input  16  decoder's current pc; marks the oldest byte still needed.
REQ-009 fetch_req  output  1  bus read request.
REQ-010 fetch_addr  output  20  physical address, (ps<<4)+fetch_pc, with the sum taken mod 2^20.
REQ-011 fetch_ack  input  1  one-cycle strobe indicating that fetch_data is valid.
REQ-012 fetch_data  input  16  bus word; [7:0] is the even byte and [15:8] is the odd byte.
REQ-013 ipq  output  8x8  byte array; the byte at offset A SHALL reside in ipq[A[2:0]].
REQ-014 ipq_len  output  4  valid bytes from decode_pc onward, in the range 0..IPQ_MAX.

Function
REQ-015 The block SHALL keep a 16-bit fetch_pc, the offset of the next byte to fetch; ipq_len SHALL equal fetch_pc-decode_pc (mod 2^16), registered.
REQ-016 Free space SHALL be IPQ_MAX-ipq_len.
REQ-017 Bus FSM states SHALL be IDLE, REQ and DISCARD.
REQ-018 In IDLE, the FSM SHALL go to REQ with fetch_req=1 on the next cycle when either condition holds:
- fetch_pc even and free>=2;
- fetch_pc odd and free>=1.
REQ-019 While in REQ or DISCARD, fetch_req and fetch_addr SHALL be held stable until fetch_ack.
REQ-020 On fetch_ack in REQ with fetch_pc even, the block SHALL write fetch_data[7:0] to slot fetch_pc[2:0] and fetch_data[15:8] to slot fetch_pc[2:0]+1, then set fetch_pc+=2.
REQ-021 On fetch_ack in REQ with fetch_pc odd, the block SHALL write fetch_data[15:8] only, then set fetch_pc+=1.
REQ-022 After any fetch_ack the FSM SHALL return to IDLE and fetch_req SHALL drop the same edge; there are no back-to-back requests without an IDLE cycle.
REQ-023 Written bytes SHALL become visible in ipq_len one cycle after the fetch_ack edge.
REQ-024 On set_pc, the block SHALL set fetch_pc<=new_pc and ipq_len<=0.
- If the FSM is in REQ without fetch_ack, it SHALL go to DISCARD.
- If fetch_ack is present in the same cycle as set_pc, the data SHALL be dropped and the FSM SHALL go to IDLE.
REQ-025 In DISCARD, fetch_ack data SHALL be dropped, the FSM SHALL go to IDLE, and fetch_pc SHALL be unchanged.
REQ-026 set_pc while in DISCARD SHALL update fetch_pc and remain in DISCARD.
REQ-027 fetch_pc and decode_pc SHALL wrap mod 2^16 within the segment; a queue spanning FFFF->0000 SHALL report the correct ipq_len.
REQ-028 Slots not covered by ipq_len SHALL hold undefined contents and SHALL NOT be consumed by the decoder.
REQ-029 When ce=0, fetch_req and fetch_addr SHALL hold, and a fetch_ack arriving with ce=0 SHALL be ignored; the bus SHALL only ack while ce=1.

Reset
REQ-030 Reset SHALL force the following, regardless of ce:
- fetch_pc=0, ipq_len=0, FSM=IDLE, fetch_req=0;
- fetch_addr=0, all ipq bytes=00h.
REQ-031 Reset SHALL abandon an outstanding request, including one in DISCARD; an ack arriving after reset SHALL be ignored in IDLE.

Configuration
REQ-032 With NEC_IPQ_LIMIT6_EN defined, IPQ_MAX SHALL be 6 (V30 queue depth), so fetching stops at ipq_len=6; the ipq array SHALL remain 8 slots wide and address-indexed.
REQ-033 Without NEC_IPQ_LIMIT6_EN, IPQ_MAX SHALL be 8.

Verification
REQ-034 Stimulus: reset, then set_pc with new_pc=0100h, ps=F000h, and immediate acks. Required response: fetch_addr sequence F0100h, F0102h, F0104h, F0106h; ipq_len reaches 8 and fetch_req stays 0 while decode_pc=0100h.
REQ-035 Stimulus: set_pc with new_pc=0013h, fetch_data=AABBh. Required response: first fetch_addr=(ps<<4)+13h, only AAh written to ipq[3], ipq_len=1; the next request is at offset 0014h.
REQ-036 Stimulus: set_pc asserted while in REQ, fetch_ack delayed 3 cycles. Required response: the FSM enters DISCARD, the ack data does not appear in ipq, and the next request uses new_pc.
REQ-037 Stimulus: fetch_pc=FFFEh, decode_pc=FFFCh, ack 1234h. Required response: ipq[6]=34h, ipq[7]=12h, fetch_pc=0000h, ipq_len=4.
REQ-038 Stimulus: NEC_IPQ_LIMIT6_EN defined, decode_pc static. Required response: ipq_len saturates at 6; advancing decode_pc by 2 triggers exactly one further word fetch.
REQ-039 Stimulus: reset asserted while in REQ with ce=0. Required response: fetch_req=0 and ipq_len=0 on the next edge.
